mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
//  CPU-side bus controller placed directly upstream of the 512x32 block-RAM memory (synchronous read, 1-cycle latency).
//  Accepts one CPU request at a time over a REQ/ACK handshake.
//  Decodes the word address to RAM, IO space (timer 0xC000.., display/led 0xF000..) or unmapped.
//  Drives RAM chip-select/write strobes, captures registered read data and bounds slow IO accesses with a timeout.
// PARAMETERS
//  MEM_AW      9        RAM word-address width; RAM window = 0 .. 2**MEM_AW-1
//  TIMEOUT     15       max IO_WAIT cycles before the access aborts with ERR (1..255)
//  UNMAP_VAL   32'h0    read data returned for unmapped addresses
// PORTS
//  CLK      in   1   system clock, rising edge
//  RESET    in   1   asynchronous, active-high reset
//  CPU_A    in   32  word address
//  CPU_DI   in   32  write data
//  CPU_WR   in   1   1=write, 0=read
//  CPU_REQ  in   1   request; held with A/DI/WR until ACK
//  CPU_DO   out  32  read data, valid while CPU_ACK=1
//  CPU_ACK  out  1   one-cycle completion pulse
//  CPU_ERR  out  1   valid with ACK: unmapped access or IO timeout
//  MEM_A    out  32  RAM address (latched CPU_A)
//  MEM_I    out  32  RAM write data
//  MEM_CS   out  1   RAM enable
//  MEM_WR   out  1   RAM write enable
//  MEM_O    in   32  RAM read data, valid the cycle after MEM_CS
//  IO_A     out  16  IO address (latched CPU_A[15:0])
//  IO_DO    out  32  IO write data
//  IO_CS    out  1   IO select
//  IO_WR    out  1   IO write strobe
//  IO_DI    in   32  IO read data, combinational, valid while IO_CS=1 and IO_WAIT=0
//  IO_WAIT  in   1   IO stretch request
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0: CPU_DO, CPU_ACK, CPU_ERR, MEM_*, IO_*.
//  Reset mid-access aborts it. Strobes drop asynchronously. No ACK is issued. A RAM write in flight may or may not be committed.
//  All outputs are registered.
//  Decode, using the address latched at accept:
//   - A[31:MEM_AW]==0 -> RAM
//   - A[31:16]==0 and A[15:14]==2'b11 -> IO
//   - anything else -> UNMAP
//  States: IDLE, MEM, MEMCAP, IO, DONE.
//  Cycle 0: IDLE with CPU_REQ=1. Latch A, DI and WR, then decode.
//  RAM path:
//   - MEM: cycle 1, MEM_CS=1 and MEM_WR=WR.
//   - Read: MEMCAP in cycle 2 captures MEM_O into CPU_DO. DONE in cycle 3.
//   - Write: goes from MEM straight to DONE in cycle 2, with CPU_DO=0.
//  IO path:
//   - IO: IO_CS=1 and IO_WR=WR, held while IO_WAIT=1.
//   - The first cycle with IO_WAIT=0 captures IO_DI (read) and goes to DONE.
//   - A wait counter counts IO_WAIT cycles. When it reaches TIMEOUT, drop IO_CS, set ERR=1, CPU_DO=0, go to DONE.
//   - IO_WAIT is ignored outside IO state.
//  UNMAP: IDLE -> DONE next cycle, CPU_DO=UNMAP_VAL, ERR=1, no strobes asserted.
//  DONE: CPU_ACK=1 for exactly one cycle, then back to IDLE.
//  CPU_DO and CPU_ERR hold their value until the next capture.
//  A REQ still high in the cycle after ACK is accepted as a new request, so back-to-back RAM reads run at 4 cycles each.
//  Latency from the accept edge to ACK high:
//   - RAM read: 3 cycles
//   - RAM write: 2 cycles
//   - IO access: 2+waits cycles
//   - unmapped: 1 cycle
//  Address boundaries:
//   - 0x1FF -> RAM; 0x200 -> UNMAP; 0xBFFF -> UNMAP; 0xC000 -> IO; 0xFFFF -> IO; 0x10000 -> UNMAP.
//   - No wrap-around: high address bits are never truncated into RAM.
//  Strobe exclusivity: MEM_CS and IO_CS are never both 1. Each is high for exactly the cycles stated above.
//  Signal changes while busy: changes on CPU_A/DI/WR after accept have no effect.
// TESTING
//  1 RAM read: preload word 0x000=0400C003, REQ A=0 WR=0 -> MEM_CS high 1 cycle, ACK 3 cycles after accept, CPU_DO=0400C003, ERR=0.
//  2 RAM write then read: write 0x1FF=DEADBEEF -> ACK at +2, MEM_WR=1 one cycle; read 0x1FF -> DEADBEEF.
//  3 IO with waits: REQ A=0xC002 read, IO_WAIT=1 for 3 cycles, IO_DI=0x1234 -> IO_CS held 4 cycles, ACK at +5, DO=0x1234, ERR=0.
//  4 IO timeout: A=0xF001 write, IO_WAIT stuck 1 -> IO_CS drops after TIMEOUT cycles, ACK with ERR=1, DO=0.
//  5 Unmapped/boundaries: A=0x200 and 0x10000 -> ACK at +1, ERR=1, DO=UNMAP_VAL, no MEM_CS/IO_CS; 0xC000 -> IO, 0x1FF -> RAM.
//  6 Reset mid-read: assert RESET while in MEMCAP -> all outputs 0 immediately, no ACK; next REQ after release completes normally.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
//   CPU-side bus controller in front of a synchronous-read block RAM
//   (1-cycle read latency) and a slow, stretchable IO space. One CPU
//   request is handled at a time over a REQ/ACK handshake. The word address
//   latched at accept is decoded to RAM, IO or unmapped. Slow IO accesses are
//   bounded by a wait-cycle timeout.
//
//   Ports
//     CLK, RESET       clock (rising edge), asynchronous active-high reset
//     CPU_A/DI/WR/REQ  CPU request: word address, write data, write flag,
//                      request (held until ACK)
//     CPU_DO/ACK/ERR   read data, one-cycle completion pulse, error flag
//                      (unmapped or IO timeout); DO/ERR hold until next capture
//     MEM_A/I/CS/WR    RAM address, write data, enable, write enable
//     MEM_O            RAM read data, valid the cycle after MEM_CS
//     IO_A/DO/CS/WR    IO address (low 16 bits), write data, select, write
//     IO_DI, IO_WAIT   IO read data (combinational), stretch request
//
//   Every output is a register; the comb process computes next values.
module mem_bus_ctrl #(
  parameter int unsigned MEM_AW    = 9,
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [31:0] UNMAP_VAL = 32'h0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] CPU_A,
  input  logic [31:0] CPU_DI,
  input  logic        CPU_WR,
  input  logic        CPU_REQ,
  output logic [31:0] CPU_DO,
  output logic        CPU_ACK,
  output logic        CPU_ERR,
  output logic [31:0] MEM_A,
  output logic [31:0] MEM_I,
  output logic        MEM_CS,
  output logic        MEM_WR,
  input  logic [31:0] MEM_O,
  output logic [15:0] IO_A,
  output logic [31:0] IO_DO,
  output logic        IO_CS,
  output logic        IO_WR,
  input  logic [31:0] IO_DI,
  input  logic        IO_WAIT
);

  typedef enum logic [2:0] {
    S_IDLE, S_MEM, S_MEMCAP, S_IO, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    R_RAM, R_IO, R_UNMAP
  } region_t;

  // The wait counter is compared against TIMEOUT-1: the cycle in which it
  // matches is the TIMEOUT-th waited cycle, so IO_CS is high for exactly
  // TIMEOUT cycles when IO_WAIT never releases.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  // Full 32-bit compares: high address bits never alias into RAM or IO.
  function automatic region_t decode(input logic [31:0] a);
    if ((a >> MEM_AW) == 32'd0)
      return R_RAM;
    if (a[31:16] == 16'd0 && a[15:14] == 2'b11)
      return R_IO;
    return R_UNMAP;
  endfunction

  state_t      state, state_d;
  logic        wr_q, wr_d;
  logic [7:0]  wcnt, wcnt_d;

  logic [31:0] cpu_do_d;
  logic        cpu_ack_d, cpu_err_d;
  logic [31:0] mem_a_d, mem_i_d;
  logic        mem_cs_d, mem_wr_d;
  logic [15:0] io_a_d;
  logic [31:0] io_do_d;
  logic        io_cs_d, io_wr_d;

  always_comb begin
    state_d   = state;
    wr_d      = wr_q;
    wcnt_d    = wcnt;
    cpu_do_d  = CPU_DO;
    cpu_err_d = CPU_ERR;
    cpu_ack_d = 1'b0;
    mem_a_d   = MEM_A;
    mem_i_d   = MEM_I;
    mem_cs_d  = 1'b0;
    mem_wr_d  = 1'b0;
    io_a_d    = IO_A;
    io_do_d   = IO_DO;
    io_cs_d   = 1'b0;
    io_wr_d   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (CPU_REQ) begin
          wr_d = CPU_WR;
          unique case (decode(CPU_A))
            R_RAM: begin
              mem_a_d  = CPU_A;
              mem_i_d  = CPU_DI;
              mem_cs_d = 1'b1;
              mem_wr_d = CPU_WR;
              state_d  = S_MEM;
            end
            R_IO: begin
              io_a_d  = CPU_A[15:0];
              io_do_d = CPU_DI;
              io_cs_d = 1'b1;
              io_wr_d = CPU_WR;
              wcnt_d  = 8'd0;
              state_d = S_IO;
            end
            default: begin
              cpu_do_d  = UNMAP_VAL;
              cpu_err_d = 1'b1;
              cpu_ack_d = 1'b1;
              state_d   = S_DONE;
            end
          endcase
        end
      end

      S_MEM: begin
        if (wr_q) begin
          cpu_do_d  = 32'd0;
          cpu_err_d = 1'b0;
          cpu_ack_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_MEMCAP;
        end
      end

      // RAM output is valid now, one cycle after the enable cycle.
      S_MEMCAP: begin
        cpu_do_d  = MEM_O;
        cpu_err_d = 1'b0;
        cpu_ack_d = 1'b1;
        state_d   = S_DONE;
      end

      S_IO: begin
        if (!IO_WAIT) begin
          cpu_do_d  = wr_q ? 32'd0 : IO_DI;
          cpu_err_d = 1'b0;
          cpu_ack_d = 1'b1;
          state_d   = S_DONE;
        end else if (wcnt == WAIT_LAST) begin
          cpu_do_d  = 32'd0;
          cpu_err_d = 1'b1;
          cpu_ack_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wcnt_d  = wcnt + 8'd1;
          io_cs_d = 1'b1;
          io_wr_d = wr_q;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      wr_q    <= 1'b0;
      wcnt    <= 8'd0;
      CPU_DO  <= 32'd0;
      CPU_ACK <= 1'b0;
      CPU_ERR <= 1'b0;
      MEM_A   <= 32'd0;
      MEM_I   <= 32'd0;
      MEM_CS  <= 1'b0;
      MEM_WR  <= 1'b0;
      IO_A    <= 16'd0;
      IO_DO   <= 32'd0;
      IO_CS   <= 1'b0;
      IO_WR   <= 1'b0;
    end else begin
      state   <= state_d;
      wr_q    <= wr_d;
      wcnt    <= wcnt_d;
      CPU_DO  <= cpu_do_d;
      CPU_ACK <= cpu_ack_d;
      CPU_ERR <= cpu_err_d;
      MEM_A   <= mem_a_d;
      MEM_I   <= mem_i_d;
      MEM_CS  <= mem_cs_d;
      MEM_WR  <= mem_wr_d;
      IO_A    <= io_a_d;
      IO_DO   <= io_do_d;
      IO_CS   <= io_cs_d;
      IO_WR   <= io_wr_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: block-RAM and IO device models around the DUT,
// a request driver that pushes predicted responses into a queue, and a
// negedge monitor that pops and compares on every ACK.
module tb_mem_bus_ctrl;

  localparam int          TIMEOUT   = 15;
  localparam logic [31:0] UNMAP_VAL = 32'h0;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] CPU_A = '0, CPU_DI = '0;
  logic        CPU_WR = 1'b0, CPU_REQ = 1'b0;
  logic [31:0] CPU_DO;
  logic        CPU_ACK, CPU_ERR;
  logic [31:0] MEM_A, MEM_I;
  logic        MEM_CS, MEM_WR;
  logic [31:0] MEM_O = '0;
  logic [15:0] IO_A;
  logic [31:0] IO_DO;
  logic        IO_CS, IO_WR;
  logic [31:0] IO_DI;
  logic        IO_WAIT;

  mem_bus_ctrl #(.MEM_AW(9), .TIMEOUT(TIMEOUT), .UNMAP_VAL(UNMAP_VAL)) dut (
    .CLK(CLK), .RESET(RESET),
    .CPU_A(CPU_A), .CPU_DI(CPU_DI), .CPU_WR(CPU_WR), .CPU_REQ(CPU_REQ),
    .CPU_DO(CPU_DO), .CPU_ACK(CPU_ACK), .CPU_ERR(CPU_ERR),
    .MEM_A(MEM_A), .MEM_I(MEM_I), .MEM_CS(MEM_CS), .MEM_WR(MEM_WR), .MEM_O(MEM_O),
    .IO_A(IO_A), .IO_DO(IO_DO), .IO_CS(IO_CS), .IO_WR(IO_WR),
    .IO_DI(IO_DI), .IO_WAIT(IO_WAIT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Block RAM environment: 512x32, synchronous read, preload port.
  logic [31:0] ram [512];
  logic        ld_en = 1'b0;
  logic [8:0]  ld_a = '0;
  logic [31:0] ld_d = '0;
  always @(posedge CLK) begin
    if (ld_en) ram[ld_a] <= ld_d;
    else if (MEM_CS) begin
      if (MEM_WR) ram[MEM_A[8:0]] <= MEM_I;
      MEM_O <= ram[MEM_A[8:0]];
    end
  end

  // IO device: stretches the first io_waits select cycles; random noise on
  // IO_WAIT whenever it is not selected.
  int          io_waits = 0;
  int          io_cnt = 0;
  logic        io_noise = 1'b0;
  logic [31:0] io_rdata = '0;
  always @(posedge CLK) begin
    io_cnt   <= IO_CS ? io_cnt + 1 : 0;
    io_noise <= 1'($urandom_range(0, 1));
  end
  assign IO_WAIT = IO_CS ? (io_cnt < io_waits) : io_noise;
  assign IO_DI   = io_rdata;

  // Reference model: memory image plus address-range rules.
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [31:0] dout;
    logic        err;
    int          lat;
    int          mcs;
    int          mwr;
    int          ics;
    int          issue;
  } exp_t;

  logic [31:0] model_mem [512];
  exp_t        q [$];

  task automatic predict(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input int waits, input logic [31:0] rd, output exp_t e);
    e.addr = a; e.wr = w; e.data = d; e.issue = cyc;
    e.mcs = 0; e.mwr = 0; e.ics = 0;
    if (a < 32'd512) begin
      e.err = 1'b0; e.mcs = 1;
      if (w) begin
        model_mem[a[8:0]] = d; e.dout = 32'd0; e.lat = 2; e.mwr = 1;
      end else begin
        e.dout = model_mem[a[8:0]]; e.lat = 3;
      end
    end else if (a >= 32'hC000 && a <= 32'hFFFF) begin
      if (waits >= TIMEOUT) begin
        e.dout = 32'd0; e.err = 1'b1; e.lat = 1 + TIMEOUT; e.ics = TIMEOUT;
      end else begin
        e.dout = w ? 32'd0 : rd; e.err = 1'b0; e.lat = 2 + waits; e.ics = waits + 1;
      end
    end else begin
      e.dout = UNMAP_VAL; e.err = 1'b1; e.lat = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    logic [149:0] v;
    v = {CPU_DO, CPU_ACK, CPU_ERR, MEM_A, MEM_I, MEM_CS, MEM_WR,
         IO_A, IO_DO, IO_CS, IO_WR};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: outputs %h, expected all zero", nm, v);
    end
  endtask

  // Monitor
  int   mcs = 0, mwr = 0, ics = 0;
  logic prev_ack = 1'b0;
  always @(negedge CLK) begin
    if (RESET) begin
      mcs = 0; mwr = 0; ics = 0; prev_ack = 1'b0;
      q.delete();
    end else begin
      if (MEM_CS && IO_CS) chk("strobe_exclusive", {31'd0, IO_CS}, 32'd0);
      if (MEM_CS) begin
        mcs++;
        if (MEM_WR) mwr++;
        if (q.size() == 0) chk("mem_cs_unexpected", {31'd0, MEM_CS}, 32'd0);
        else begin
          chk("mem_a", MEM_A, q[0].addr);
          chk("mem_wr", {31'd0, MEM_WR}, {31'd0, q[0].wr});
          if (q[0].wr) chk("mem_i", MEM_I, q[0].data);
        end
      end
      if (IO_CS) begin
        ics++;
        if (q.size() == 0) chk("io_cs_unexpected", {31'd0, IO_CS}, 32'd0);
        else begin
          chk("io_a", {16'd0, IO_A}, {16'd0, q[0].addr[15:0]});
          chk("io_wr", {31'd0, IO_WR}, {31'd0, q[0].wr});
          if (q[0].wr) chk("io_do", IO_DO, q[0].data);
        end
      end
      if (CPU_ACK) begin
        chk("ack_width", {31'd0, prev_ack}, 32'd0);
        if (q.size() == 0) chk("ack_unexpected", {31'd0, CPU_ACK}, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("cpu_do", CPU_DO, e.dout);
          chk("cpu_err", {31'd0, CPU_ERR}, {31'd0, e.err});
          chk("latency", 32'(cyc - e.issue), 32'(e.lat));
          chk("mem_cs_cycles", 32'(mcs), 32'(e.mcs));
          chk("mem_wr_cycles", 32'(mwr), 32'(e.mwr));
          chk("io_cs_cycles", 32'(ics), 32'(e.ics));
        end
        mcs = 0; mwr = 0; ics = 0;
      end
      prev_ack = CPU_ACK;
    end
  end

  // Driver: called #1 after a rising edge; returns #1 after the edge that
  // ends the ACK cycle, with REQ still high (back-to-back unless gap > 0).
  task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input int waits, input logic [31:0] rd, input int gap);
    exp_t e;
    bit   got;
    if (gap > 0) begin
      CPU_REQ = 1'b0;
      repeat (gap) @(posedge CLK);
      #1;
    end
    CPU_A = a; CPU_WR = w; CPU_DI = d;
    io_waits = waits; io_rdata = rd;
    CPU_REQ = 1'b1;
    predict(a, w, d, waits, rd, e);
    q.push_back(e);
    @(posedge CLK); #1;
    CPU_A = $urandom(); CPU_DI = $urandom(); CPU_WR = 1'($urandom_range(0, 1));
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge CLK);
      if (CPU_ACK) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: no ACK for addr %h after 400 cycles, expected ACK", a);
      if (q.size() > 0) void'(q.pop_front());
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    #1 RESET = 1'b1;
    #1 chk_all_zero("reset_state");

    for (int i = 0; i < 512; i++) begin
      @(posedge CLK); #1;
      ld_en = 1'b1;
      ld_a  = 9'(i);
      ld_d  = (i == 0) ? 32'h0400C003 : $urandom();
      model_mem[i] = ld_d;
    end
    @(posedge CLK); #1;
    ld_en = 1'b0;
    @(negedge CLK); #1 RESET = 1'b0;
    @(posedge CLK); #1;

    do_req(32'h0,     1'b0, 32'h0,        0,     32'h0,    1);
    do_req(32'h1FF,   1'b1, 32'hDEADBEEF, 0,     32'h0,    0);
    do_req(32'h1FF,   1'b0, 32'h0,        0,     32'h0,    0);
    do_req(32'hC002,  1'b0, 32'h0,        3,     32'h1234, 0);
    do_req(32'hF001,  1'b1, 32'h55AA55AA, 10000, 32'h0,    0);
    do_req(32'h200,   1'b0, 32'h0,        0,     32'h0,    0);
    do_req(32'h10000, 1'b0, 32'h0,        0,     32'h0,    0);
    do_req(32'hBFFF,  1'b1, 32'h11111111, 0,     32'h0,    1);
    do_req(32'hC000,  1'b0, 32'h0,        0,     32'hCAFE, 0);
    do_req(32'hFFFF,  1'b1, 32'h77778888, 2,     32'h0,    0);
    do_req(32'h1FF,   1'b0, 32'h0,        0,     32'h0,    0);
    CPU_REQ = 1'b0;

    // Reset while the read sits in MEMCAP.
    @(posedge CLK); #1;
    begin
      exp_t e;
      CPU_A = 32'h5; CPU_WR = 1'b0; CPU_DI = 32'h0; CPU_REQ = 1'b1;
      predict(32'h5, 1'b0, 32'h0, 0, 32'h0, e);
      q.push_back(e);
    end
    @(posedge CLK); #1 CPU_REQ = 1'b0;
    @(posedge CLK); #2 RESET = 1'b1;
    #1 chk_all_zero("reset_mid_read");
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1 RESET = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("no_ack_after_reset", {31'd0, CPU_ACK}, 32'd0);
    end
    @(posedge CLK); #1;
    do_req(32'h5, 1'b0, 32'h0, 0, 32'h0, 0);

    for (int n = 0; n < 160; n++) begin
      int          r;
      int          waits;
      int          gap;
      logic [31:0] a;
      r = int'($urandom_range(0, 99));
      waits = 0;
      if (r < 40)
        a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15))
                                        : 32'h1F0 + 32'($urandom_range(0, 15));
      else if (r < 65) begin
        a = 32'hC000 + 32'($urandom_range(0, 16383));
        waits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 3))
                                            : int'($urandom_range(0, 4));
      end else begin
        case ($urandom_range(0, 6))
          0:       a = 32'h200;
          1:       a = 32'hBFFF;
          2:       a = 32'h10000;
          3:       a = 32'hFFFFFFFF;
          4:       a = 32'h80000000 + 32'($urandom_range(0, 511));
          5:       a = 32'h0001C000 + 32'($urandom_range(0, 16383));
          default: a = 32'h400 + 32'($urandom_range(0, 31743));
        endcase
      end
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_req(a, 1'($urandom_range(0, 1)), $urandom(), waits, $urandom(), gap);
    end
    CPU_REQ = 1'b0;

    repeat (5) @(negedge CLK);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
